// File: rtl/branch_compare_seq_pkg.sv
// Shared types and encodings for the chunked branch comparator: FSM states,
// condition codes, branch encodings and the condition-versus-branch decode.
package branch_compare_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_SCAN = 2'b01,
        S_HOLD = 2'b10
    } state_t;

    localparam logic [2:0] CMP_EQ = 3'b000;
    localparam logic [2:0] CMP_NE = 3'b001;
    localparam logic [2:0] CMP_LT = 3'b010;
    localparam logic [2:0] CMP_GE = 3'b011;
    localparam logic [2:0] CMP_GT = 3'b100;
    localparam logic [2:0] CMP_LE = 3'b101;

    localparam logic [1:0] BR_EQ = 2'b00;
    localparam logic [1:0] BR_LT = 2'b01;
    localparam logic [1:0] BR_GT = 2'b10;

    // Codes 11x fall through to "never taken".
    function automatic logic eval_taken(input logic [2:0] c, input logic [1:0] br);
        case (c)
            CMP_EQ:  return br == BR_EQ;
            CMP_NE:  return br != BR_EQ;
            CMP_LT:  return br == BR_LT;
            CMP_GE:  return br != BR_LT;
            CMP_GT:  return br == BR_GT;
            CMP_LE:  return br != BR_GT;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/branch_compare_seq_cmp_chunk.sv
// Combinational unsigned magnitude compare of one CHUNK-bit slice,
// producing the 2-bit branch encoding.
module cmp_chunk
    import branch_compare_seq_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic [1:0]       br
);

    always_comb begin
        if (a < b)      br = BR_LT;
        else if (a > b) br = BR_GT;
        else            br = BR_EQ;
    end

endmodule

// File: rtl/branch_compare_seq.sv
// Multi-cycle OP1/R15 branch comparator: scans CHUNK bits per cycle from the
// MSB end, stops at the first differing chunk and holds the result until taken.
module branch_compare_seq
    import branch_compare_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] r15,
    input  logic             signed_mode,
    input  logic [2:0]       cond,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       branch,
    output logic             taken
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NCHUNK - 1);

    if (WIDTH % CHUNK != 0) begin : g_width_check
        $error("branch_compare_seq: WIDTH must be a multiple of CHUNK");
    end

    state_t           state, next_state;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] op_a, op_b;
    logic [2:0]       cond_q;
    logic [1:0]       chunk_br;
    logic             load, step, finish;

    cmp_chunk #(.CHUNK(CHUNK)) u_cmp (
        .a  (op_a[idx*CHUNK +: CHUNK]),
        .b  (op_b[idx*CHUNK +: CHUNK]),
        .br (chunk_br)
    );

    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned, which would infer a latch.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            S_IDLE: if (in_valid) begin
                next_state = S_SCAN;
                load       = 1'b1;
            end
            S_SCAN: if (chunk_br != BR_EQ || idx == '0) begin
                next_state = S_HOLD;
                finish     = 1'b1;
            end else begin
                step = 1'b1;
            end
            S_HOLD: if (out_ready) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst)        state <= S_IDLE;
        else if (flush) state <= S_IDLE;
        else            state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx    <= IDX_TOP;
            branch <= BR_EQ;
            taken  <= 1'b0;
        end else if (flush) begin
            idx <= IDX_TOP;
        end else begin
            if (load) idx <= IDX_TOP;
            if (step) idx <= idx - 1'b1;
            if (finish) begin
                branch <= chunk_br;
                taken  <= eval_taken(cond_q, chunk_br);
            end
        end
    end

    // NOTE: operand registers carry no reset; they are only read after a load,
    // so resetting them would cost reset fan-out for no behavioural benefit.
    // Flipping both MSBs maps two's-complement order onto unsigned order.
    always_ff @(posedge clk) begin
        if (load && !rst && !flush) begin
            op_a   <= {op1[WIDTH-1] ^ signed_mode, op1[WIDTH-2:0]};
            op_b   <= {r15[WIDTH-1] ^ signed_mode, r15[WIDTH-2:0]};
            cond_q <= cond;
        end
    end

    assign in_ready  = (state == S_IDLE) && !rst;
    assign out_valid = (state == S_HOLD);

endmodule

// File: tb/tb_branch_compare_seq.sv
// Directed bench for branch_compare_seq (WIDTH=16, CHUNK=4): vector table plus
// hand-written backpressure, flush and reset-in-HOLD sequences.
module tb_branch_compare_seq;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, signed_mode, out_valid, out_ready, taken;
    logic [15:0] op1, r15;
    logic [2:0]  cond;
    logic [1:0]  branch;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sm;
        logic [2:0]  c;
        logic [1:0]  exp_br;
        logic        exp_taken;
        int          exp_k;
    } vec_t;

    vec_t vecs[13];

    branch_compare_seq #(.WIDTH(16), .CHUNK(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op1         (op1),
        .r15         (r15),
        .signed_mode (signed_mode),
        .cond        (cond),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .branch      (branch),
        .taken       (taken)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drive one request and count edges until out_valid; leaves the DUT in HOLD.
    task automatic issue(input vec_t v, output int k);
        @(negedge clk);
        check("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
        op1 = v.a; r15 = v.b; signed_mode = v.sm; cond = v.c; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (!out_valid && k < 20);
    endtask

    task automatic release_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_after_handshake", {31'b0, out_valid}, 32'd0);
        check("in_ready_after_handshake", {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        int k;
        logic [1:0] held_br;
        logic       held_taken;
        vec_t       v;

        vecs[0]  = '{16'h0005, 16'h0007, 1'b0, 3'b010, 2'b01, 1'b1, 4};
        vecs[1]  = '{16'h0007, 16'h0005, 1'b0, 3'b100, 2'b10, 1'b1, 4};
        vecs[2]  = '{16'h0007, 16'h0005, 1'b0, 3'b101, 2'b10, 1'b0, 4};
        vecs[3]  = '{16'h0007, 16'h0007, 1'b0, 3'b000, 2'b00, 1'b1, 4};
        vecs[4]  = '{16'h0007, 16'h0007, 1'b0, 3'b001, 2'b00, 1'b0, 4};
        vecs[5]  = '{16'h0000, 16'h0000, 1'b0, 3'b000, 2'b00, 1'b1, 4};
        vecs[6]  = '{16'hFFFF, 16'hFFFF, 1'b1, 3'b000, 2'b00, 1'b1, 4};
        vecs[7]  = '{16'h8000, 16'h0001, 1'b1, 3'b010, 2'b01, 1'b1, 1};
        vecs[8]  = '{16'h8000, 16'h0001, 1'b0, 3'b010, 2'b10, 1'b0, 1};
        vecs[9]  = '{16'hFFFF, 16'h0001, 1'b1, 3'b011, 2'b01, 1'b0, 1};
        vecs[10] = '{16'h1234, 16'h1243, 1'b0, 3'b101, 2'b01, 1'b1, 3};
        vecs[11] = '{16'h0005, 16'h0007, 1'b0, 3'b110, 2'b01, 1'b0, 4};
        vecs[12] = '{16'hFFFF, 16'hFFFF, 1'b0, 3'b111, 2'b00, 1'b0, 4};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op1 = '0; r15 = '0; signed_mode = 1'b0; cond = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", {31'b0, in_ready}, 32'd0);
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_branch", {30'b0, branch}, 32'd0);
        check("reset_taken", {31'b0, taken}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("in_ready_after_reset", {31'b0, in_ready}, 32'd1);

        for (int i = 0; i < 13; i++) begin
            issue(vecs[i], k);
            check($sformatf("vec%0d_out_valid", i), {31'b0, out_valid}, 32'd1);
            check($sformatf("vec%0d_latency", i), k, vecs[i].exp_k);
            check($sformatf("vec%0d_branch", i), {30'b0, branch}, {30'b0, vecs[i].exp_br});
            check($sformatf("vec%0d_taken", i), {31'b0, taken}, {31'b0, vecs[i].exp_taken});
            release_result();
        end

        // Backpressure: result held for 3 cycles while new requests are ignored.
        v = '{16'h0005, 16'h0007, 1'b0, 3'b010, 2'b01, 1'b1, 4};
        issue(v, k);
        check("bp_out_valid", {31'b0, out_valid}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            op1 = 16'h0009; r15 = 16'h0002; cond = 3'b000; in_valid = 1'b1;
            check($sformatf("bp%0d_in_ready", i), {31'b0, in_ready}, 32'd0);
            @(posedge clk); #1;
            check($sformatf("bp%0d_out_valid", i), {31'b0, out_valid}, 32'd1);
            check($sformatf("bp%0d_branch", i), {30'b0, branch}, 32'h1);
            check($sformatf("bp%0d_taken", i), {31'b0, taken}, 32'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        release_result();
        @(posedge clk); #1;
        check("bp_ignored_request_not_started", {31'b0, out_valid}, 32'd0);
        check("bp_still_idle", {31'b0, in_ready}, 32'd1);

        // Flush in the second SCAN cycle of a 4-chunk compare.
        held_br = branch; held_taken = taken;
        @(negedge clk);
        op1 = 16'h0007; r15 = 16'h0007; signed_mode = 1'b0; cond = 3'b000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_in_ready", {31'b0, in_ready}, 32'd1);
        check("flush_out_valid", {31'b0, out_valid}, 32'd0);
        check("flush_branch_kept", {30'b0, branch}, {30'b0, held_br});
        check("flush_taken_kept", {31'b0, taken}, {31'b0, held_taken});
        k = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) k++;
        end
        check("flush_no_out_valid", k, 0);

        // Reset while holding a result.
        v = '{16'h8000, 16'h0001, 1'b1, 3'b010, 2'b01, 1'b1, 1};
        issue(v, k);
        check("rst_hold_pre_taken", {31'b0, taken}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_hold_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_hold_branch", {30'b0, branch}, 32'd0);
        check("rst_hold_taken", {31'b0, taken}, 32'd0);
        check("rst_hold_in_ready", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_release_in_ready", {31'b0, in_ready}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
